// File: rtl/dfsr_cell_tester_if.sv
// Bundle between the cell tester and its environment: run control, result status and the cell-under-test pins.
// The master side is the tester; the slave side is the cell/test harness.
interface dfsr_cell_tester_if;
  logic       START;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [2:0] FAIL_STEP;
  logic [3:0] ERR_COUNT;
  logic       DUT_D;
  logic       DUT_RN;
  logic       DUT_SN;
  logic       DUT_CLK;
  logic       DUT_Q;

  modport master (
    input  START, DUT_Q,
    output BUSY, DONE, PASS, FAIL_STEP, ERR_COUNT,
    output DUT_D, DUT_RN, DUT_SN, DUT_CLK
  );

  modport slave (
    output START, DUT_Q,
    input  BUSY, DONE, PASS, FAIL_STEP, ERR_COUNT,
    input  DUT_D, DUT_RN, DUT_SN, DUT_CLK
  );
endinterface

// File: rtl/dfsr_cell_tester.sv
// Walks an 8-step vector table into a set/reset D flop cell and checks its synchronized Q each step.
// A run lasts LOOPS*(8*(2*SETTLE+1)+8) cycles; START edges are ignored while busy, nothing stalls the sequence.
module dfsr_cell_tester #(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               VDD,
  input  logic               VSS,
  input  logic               VPW,
  input  logic               VNW,
  dfsr_cell_tester_if.master bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_CLKHI,
    S_CLKLO,
    S_WAIT,
    S_CHECK
  } state_t;

  typedef struct packed {
    logic d;
    logic rn;
    logic sn;
    logic clk;
    logic expq;
  } vec_t;

  // Fields ordered d, rn, sn, clk, expq.
  function automatic vec_t vec_of(input logic [2:0] s);
    case (s)
      3'd0:    vec_of = 5'b10100;
      3'd1:    vec_of = 5'b11111;
      3'd2:    vec_of = 5'b01110;
      3'd3:    vec_of = 5'b01001;
      3'd4:    vec_of = 5'b01011;
      3'd5:    vec_of = 5'b00000;
      3'd6:    vec_of = 5'b01100;
      default: vec_of = 5'b11111;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_q, step_d;
  logic [LW-1:0] loop_q, loop_d;
  logic          start_q;
  logic          q_s1, q_s2;
  logic          d_q, d_d;
  logic          rn_q, rn_d;
  logic          sn_q, sn_d;
  logic          clk_q, clk_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [2:0]    fstep_q, fstep_d;
  logic [3:0]    err_q, err_d;

  vec_t       cur_vec;
  vec_t       nxt_vec;
  logic       start_rise;
  logic [3:0] err_sat;

  // Power and well pins carry no logic; folded here so they are visibly consumed.
  logic unused_pwr;
  assign unused_pwr = ^{VDD, VSS, VPW, VNW};

  assign cur_vec    = vec_of(step_q);
  assign nxt_vec    = vec_of(step_q + 3'd1);
  assign start_rise = bus.START & ~start_q;
  assign err_sat    = (err_q == 4'hF) ? err_q : err_q + 4'd1;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      loop_q  <= '0;
      start_q <= 1'b0;
      q_s1    <= 1'b0;
      q_s2    <= 1'b0;
      d_q     <= 1'b0;
      rn_q    <= 1'b0;
      sn_q    <= 1'b1;
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fstep_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      loop_q  <= loop_d;
      start_q <= bus.START;
      q_s1    <= bus.DUT_Q;
      q_s2    <= q_s1;
      d_q     <= d_d;
      rn_q    <= rn_d;
      sn_q    <= sn_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fstep_q <= fstep_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    loop_d  = loop_q;
    d_d     = d_q;
    rn_d    = rn_q;
    sn_d    = sn_q;
    clk_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fstep_d = fstep_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fstep_d = '0;
          step_d  = '0;
          loop_d  = '0;
          cnt_d   = '0;
          d_d     = vec_of(3'd0).d;
          rn_d    = vec_of(3'd0).rn;
          sn_d    = vec_of(3'd0).sn;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (cur_vec.clk) begin
            clk_d   = 1'b1;
            state_d = S_CLKHI;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLKHI: state_d = S_CLKLO;
      S_CLKLO: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (q_s2 != cur_vec.expq) begin
          err_d = err_sat;
          if (err_q == 4'd0) fstep_d = step_q;
        end
        if (step_q == 3'd7 && loop_q == LOOP_LAST) begin
          // Park the cell in reset between runs.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
          rn_d    = 1'b0;
          sn_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          step_d = step_q + 3'd1;
          if (step_q == 3'd7) loop_d = loop_q + LW'(1);
          d_d     = nxt_vec.d;
          rn_d    = nxt_vec.rn;
          sn_d    = nxt_vec.sn;
          cnt_d   = '0;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.DUT_D     = d_q;
  assign bus.DUT_RN    = rn_q;
  assign bus.DUT_SN    = sn_q;
  assign bus.DUT_CLK   = clk_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL_STEP = fstep_q;
  assign bus.ERR_COUNT = err_q;

endmodule

// File: tb/tb_dfsr_cell_tester.sv
// Bench for dfsr_cell_tester: two instances (LOOPS=1 and LOOPS=4) each driving a behavioural set/reset flop
// with selectable faults; results checked against directed constants and a step-level reference model.
module tb_dfsr_cell_tester;

  localparam int S = 2;
  // Spec vector table, bit index = step.
  localparam bit [7:0] TV_D   = 8'b1000_0011;
  localparam bit [7:0] TV_RN  = 8'b1101_1110;
  localparam bit [7:0] TV_SN  = 8'b1100_0111;
  localparam bit [7:0] TV_CLK = 8'b1001_0110;
  localparam bit [7:0] TV_Q   = 8'b1001_1010;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  logic start = 1'b0;
  logic vdd = 1'b1;
  logic vss = 1'b0;
  int   fault = 0;   // 0 good, 1 set loses to clock edge, 2 Q tied low
  int   n_chk = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  dfsr_cell_tester_if if1();
  dfsr_cell_tester_if if4();

  assign if1.START = start;
  assign if4.START = start;

  dfsr_cell_tester #(.SETTLE(S), .LOOPS(1)) dut1 (
    .CLK(CLK), .RN(RN), .VDD(vdd), .VSS(vss), .VPW(vdd), .VNW(vss), .bus(if1.master)
  );
  dfsr_cell_tester #(.SETTLE(S), .LOOPS(4)) dut4 (
    .CLK(CLK), .RN(RN), .VDD(vdd), .VSS(vss), .VPW(vdd), .VNW(vss), .bus(if4.master)
  );

  logic cq1 = 1'b0;
  logic cq4 = 1'b0;

  always @(posedge if1.DUT_CLK or if1.DUT_RN or if1.DUT_SN) begin
    if (!if1.DUT_RN)        cq1 = 1'b0;
    else if (if1.DUT_CLK)   cq1 = (!if1.DUT_SN && fault != 1) ? 1'b1 : if1.DUT_D;
    else if (!if1.DUT_SN)   cq1 = 1'b1;
  end

  always @(posedge if4.DUT_CLK or if4.DUT_RN or if4.DUT_SN) begin
    if (!if4.DUT_RN)        cq4 = 1'b0;
    else if (if4.DUT_CLK)   cq4 = (!if4.DUT_SN && fault != 1) ? 1'b1 : if4.DUT_D;
    else if (!if4.DUT_SN)   cq4 = 1'b1;
  end

  assign if1.DUT_Q = (fault == 2) ? 1'b0 : cq1;
  assign if4.DUT_Q = (fault == 2) ? 1'b0 : cq4;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Step-level model: the cell's final Q per step from its truth table, then the tester's scoring rules.
  function automatic void ref_model(input int f, input int loops,
                                    output int err, output int fs, output int cyc);
    bit q = 1'b0;
    bit obs;
    err = 0; fs = 0; cyc = 0;
    for (int l = 0; l < loops; l++) begin
      for (int s = 0; s < 8; s++) begin
        if (!TV_RN[s])                      q = 1'b0;
        else if (!TV_SN[s])                 q = (TV_CLK[s] && f == 1) ? TV_D[s] : 1'b1;
        else if (TV_CLK[s])                 q = TV_D[s];
        obs = (f == 2) ? 1'b0 : q;
        if (obs != TV_Q[s]) begin
          if (err == 0) fs = s;
          err = (err < 15) ? err + 1 : 15;
        end
        cyc += TV_CLK[s] ? 2 * S + 3 : 2 * S + 1;
      end
    end
  endfunction

  function automatic int status_vec(input logic busy, done, pass, input logic [2:0] fs,
                                    input logic [3:0] ec, input logic d, rn, sn, ck);
    return int'({busy, done, pass, fs, ec, d, rn, sn, ck});
  endfunction

  task automatic run_one(input string tag, input int f, input bit tog,
                         input int e1_err, input int e1_fs, input int e1_pass,
                         input int e4_err, input int e4_fs, input int e4_pass);
    int c1, c4, hold, base, m_err, m_fs, m_cyc;
    int pos[$];
    int epos[$];
    bit overlap, timeout;
    fault = f;
    ref_model(f, 1, m_err, m_fs, m_cyc);
    base = 0;
    for (int s = 0; s < 8; s++) begin
      if (TV_CLK[s]) epos.push_back(base + S);
      base += TV_CLK[s] ? 2 * S + 3 : 2 * S + 1;
    end
    hold = $urandom_range(0, 3);
    c1 = 0; c4 = 0; overlap = 0; timeout = 1;
    @(negedge CLK);
    start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge CLK);
      if (if1.BUSY) begin
        c1++;
        if (if1.DONE) overlap = 1;
        if (if1.DUT_CLK) pos.push_back(c1 - 1);
      end
      if (if4.BUSY) begin
        c4++;
        if (if4.DONE) overlap = 1;
      end
      if (!if1.BUSY && !if4.BUSY) begin
        timeout = 0;
        break;
      end
      // Toggle only while the short run is still busy; afterwards START holds across DONE.
      if (tog && c1 < 40)      start = 1'($urandom_range(0, 1));
      else if (!tog && n == hold) start = 1'b0;
    end
    check($sformatf("%s timeout", tag), int'(timeout), 0);
    check($sformatf("%s busy1 cycles", tag), c1, m_cyc);
    check($sformatf("%s busy4 cycles", tag), c4, 4 * m_cyc);
    check($sformatf("%s done while busy", tag), int'(overlap), 0);
    check($sformatf("%s done1", tag), int'(if1.DONE), 1);
    check($sformatf("%s pass1", tag), int'(if1.PASS), e1_pass);
    check($sformatf("%s err1", tag), int'(if1.ERR_COUNT), e1_err);
    check($sformatf("%s fail_step1", tag), int'(if1.FAIL_STEP), e1_fs);
    check($sformatf("%s done4", tag), int'(if4.DONE), 1);
    check($sformatf("%s pass4", tag), int'(if4.PASS), e4_pass);
    check($sformatf("%s err4", tag), int'(if4.ERR_COUNT), e4_err);
    check($sformatf("%s fail_step4", tag), int'(if4.FAIL_STEP), e4_fs);
    check($sformatf("%s parked rn/sn", tag), int'({if1.DUT_RN, if1.DUT_SN}), 1);
    check($sformatf("%s clk pulses", tag), pos.size(), epos.size());
    for (int k = 0; k < epos.size(); k++)
      if (k < pos.size()) check($sformatf("%s clk pulse %0d cycle", tag, k), pos[k], epos[k]);
    repeat (3) @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    check($sformatf("%s no retrigger", tag),
          int'({if1.BUSY, if4.BUSY, if1.DONE, if4.DONE}), 4'b0011);
  endtask

  typedef struct {
    int f;
    bit tog;
    int err1, fs1, pass1, err4, fs4, pass4;
  } tcase_t;

  tcase_t tbl[4];

  initial begin
    int r_err1, r_fs1, r_err4, r_fs4, r_cyc, rf;
    bit rt;
    tbl[0] = '{0, 1'b0, 0, 0, 1, 0, 0, 1};
    tbl[1] = '{1, 1'b0, 1, 4, 0, 4, 4, 0};
    tbl[2] = '{2, 1'b0, 4, 1, 0, 15, 1, 0};
    tbl[3] = '{0, 1'b1, 0, 0, 1, 0, 0, 1};

    RN = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset status dut1",
          status_vec(if1.BUSY, if1.DONE, if1.PASS, if1.FAIL_STEP, if1.ERR_COUNT,
                     if1.DUT_D, if1.DUT_RN, if1.DUT_SN, if1.DUT_CLK), 2);
    check("reset status dut4",
          status_vec(if4.BUSY, if4.DONE, if4.PASS, if4.FAIL_STEP, if4.ERR_COUNT,
                     if4.DUT_D, if4.DUT_RN, if4.DUT_SN, if4.DUT_CLK), 2);
    RN = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 4; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].f, tbl[i].tog, tbl[i].err1, tbl[i].fs1,
              tbl[i].pass1, tbl[i].err4, tbl[i].fs4, tbl[i].pass4);

    for (int i = 0; i < 5; i++) begin
      rf = $urandom_range(0, 2);
      rt = 1'($urandom_range(0, 1));
      ref_model(rf, 1, r_err1, r_fs1, r_cyc);
      ref_model(rf, 4, r_err4, r_fs4, r_cyc);
      repeat ($urandom_range(1, 6)) @(negedge CLK);
      run_one($sformatf("rnd%0d_f%0d_t%0d", i, rf, rt), rf, rt, r_err1, r_fs1,
              int'(r_err1 == 0), r_err4, r_fs4, int'(r_err4 == 0));
    end

    // Reset in the middle of a faulty run, then a clean pass.
    fault = 2;
    @(negedge CLK);
    start = 1'b1;
    repeat (20) @(negedge CLK);
    check("busy before mid-run reset", int'(if1.BUSY & if4.BUSY), 1);
    #2;
    RN = 1'b0;
    #1;
    check("mid-run reset dut1",
          status_vec(if1.BUSY, if1.DONE, if1.PASS, if1.FAIL_STEP, if1.ERR_COUNT,
                     if1.DUT_D, if1.DUT_RN, if1.DUT_SN, if1.DUT_CLK), 2);
    check("mid-run reset dut4",
          status_vec(if4.BUSY, if4.DONE, if4.PASS, if4.FAIL_STEP, if4.ERR_COUNT,
                     if4.DUT_D, if4.DUT_RN, if4.DUT_SN, if4.DUT_CLK), 2);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    RN = 1'b1;
    repeat (2) @(negedge CLK);
    check("no resume after reset", int'(if1.BUSY | if4.BUSY), 0);
    run_one("after_reset", 0, 1'b0, 0, 0, 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
